// File: rtl/imm_gen_pipe.sv
// Registered RV immediate generator for the ID stage: decodes the opcode,
// builds the sign-extended immediate, format code and illegal flag behind a valid/ready register.
module imm_gen_pipe #(
    parameter int XLEN      = 32,
    parameter int SUPPORT_W = 0,
    parameter int TAG_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    typedef enum logic [6:0] {
        OP_LOAD     = 7'b0000011,
        OP_MISC_MEM = 7'b0001111,
        OP_IMM      = 7'b0010011,
        OP_AUIPC    = 7'b0010111,
        OP_IMM_32   = 7'b0011011,
        OP_STORE    = 7'b0100011,
        OP_OP       = 7'b0110011,
        OP_LUI      = 7'b0110111,
        OP_OP_32    = 7'b0111011,
        OP_BRANCH   = 7'b1100011,
        OP_JALR     = 7'b1100111,
        OP_JAL      = 7'b1101111,
        OP_SYSTEM   = 7'b1110011
    } opcode_e;

    fmt_e               dec_fmt;
    logic               dec_illegal;
    logic signed [31:0] imm32;
    logic [XLEN-1:0]    imm_ext;
    logic               accept;
    logic               w_ok;

    assign w_ok     = (SUPPORT_W != 0);
    assign in_ready = ~out_valid | out_ready;
    assign accept   = in_valid & in_ready & ~flush;

    // Any opcode not listed (including instr[1:0] != 2'b11) lands in default.
    always_comb begin
        dec_fmt     = FMT_R;
        dec_illegal = 1'b0;
        case (in_instr[6:0])
            OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM, OP_MISC_MEM: dec_fmt = FMT_I;
            OP_IMM_32: begin
                if (w_ok) dec_fmt = FMT_I;
                else      dec_illegal = 1'b1;
            end
            OP_STORE:        dec_fmt = FMT_S;
            OP_BRANCH:       dec_fmt = FMT_B;
            OP_LUI, OP_AUIPC: dec_fmt = FMT_U;
            OP_JAL:          dec_fmt = FMT_J;
            OP_OP:           dec_fmt = FMT_R;
            OP_OP_32: begin
                if (!w_ok) dec_illegal = 1'b1;
            end
            default:         dec_illegal = 1'b1;
        endcase
    end

    always_comb begin
        imm32 = '0;
        case (dec_fmt)
            FMT_I: imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
            FMT_S: imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            FMT_B: imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                            in_instr[30:25], in_instr[11:8], 1'b0};
            FMT_U: imm32 = {in_instr[31:12], 12'b0};
            FMT_J: imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                            in_instr[20], in_instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    // Built as a signed 32-bit value, then widened so RV64 gets sign extension.
    assign imm_ext = XLEN'(imm32);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_imm     <= '0;
            out_fmt     <= '0;
            out_illegal <= 1'b0;
            out_tag     <= '0;
        end else begin
            out_valid <= accept | (out_valid & ~out_ready & ~flush);
            if (accept) begin
                out_imm     <= imm_ext;
                out_fmt     <= dec_fmt;
                out_illegal <= dec_illegal;
                out_tag     <= in_tag;
            end
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: an RV32/no-W instance and an RV64/W instance share one
// stimulus stream; a table, directed handshake sequences and random traffic are checked.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_instr;
    logic [7:0]  in_tag;

    logic        rdy_a, vld_a, ill_a;
    logic [31:0] imm_a;
    logic [2:0]  fmt_a;
    logic [7:0]  tag_a;

    logic        rdy_b, vld_b, ill_b;
    logic [63:0] imm_b;
    logic [2:0]  fmt_b;
    logic [7:0]  tag_b;

    imm_gen_pipe #(.XLEN(32), .SUPPORT_W(0), .TAG_W(8)) dut_a (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy_a),
        .in_instr(in_instr), .in_tag(in_tag), .out_valid(vld_a), .out_ready(out_ready),
        .out_imm(imm_a), .out_fmt(fmt_a), .out_illegal(ill_a), .out_tag(tag_a)
    );

    imm_gen_pipe #(.XLEN(64), .SUPPORT_W(1), .TAG_W(8)) dut_b (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy_b),
        .in_instr(in_instr), .in_tag(in_tag), .out_valid(vld_b), .out_ready(out_ready),
        .out_imm(imm_b), .out_fmt(fmt_b), .out_illegal(ill_b), .out_tag(tag_b)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference state of the output register (index 0: RV32/no-W, 1: RV64/W).
    logic        m_valid;
    logic [63:0] m_imm [2];
    logic [2:0]  m_fmt [2];
    logic        m_ill [2];
    logic [7:0]  m_tag;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Immediate computed from field positions with integer arithmetic on a sign-extended word.
    function automatic void ref_dec(input logic [31:0] ins, input bit wide, input bit w,
                                    output logic [63:0] imm, output logic [2:0] fmt,
                                    output logic ill);
        longint x;
        x   = longint'(signed'(ins));
        imm = '0;
        fmt = 3'd0;
        ill = 1'b0;
        case (ins[6:0])
            7'h03, 7'h13, 7'h67, 7'h73, 7'h0F: fmt = 3'd1;
            7'h1B: if (w) fmt = 3'd1; else ill = 1'b1;
            7'h23: fmt = 3'd2;
            7'h63: fmt = 3'd3;
            7'h37, 7'h17: fmt = 3'd4;
            7'h6F: fmt = 3'd5;
            7'h33: fmt = 3'd0;
            7'h3B: if (!w) ill = 1'b1;
            default: ill = 1'b1;
        endcase
        case (fmt)
            3'd1: imm = x >>> 20;
            3'd2: imm = ((x >>> 25) << 5) + longint'(ins[11:7]);
            3'd3: imm = ((x >>> 31) << 12) + (longint'(ins[7]) << 11)
                      + (longint'(ins[30:25]) << 5) + (longint'(ins[11:8]) << 1);
            3'd4: imm = (x >>> 12) << 12;
            3'd5: imm = ((x >>> 31) << 20) + (longint'(ins[19:12]) << 12)
                      + (longint'(ins[20]) << 11) + (longint'(ins[30:21]) << 1);
            default: imm = '0;
        endcase
        if (!wide) imm = {32'b0, imm[31:0]};
    endfunction

    task automatic step(input logic r, input logic f, input logic iv, input logic orr,
                        input logic [31:0] ins, input logic [7:0] tg);
        logic acc;
        rst = r; flush = f; in_valid = iv; out_ready = orr; in_instr = ins; in_tag = tg;
        #1;
        check("in_ready_a", {63'b0, rdy_a}, {63'b0, (!m_valid || orr)});
        check("in_ready_b", {63'b0, rdy_b}, {63'b0, (!m_valid || orr)});
        acc = iv && (!m_valid || orr) && !f;
        if (r) begin
            m_valid = 1'b0;
            m_tag   = '0;
            for (int unsigned k = 0; k < 2; k++) begin
                m_imm[k] = '0; m_fmt[k] = '0; m_ill[k] = 1'b0;
            end
        end else begin
            if (acc) begin
                ref_dec(ins, 1'b0, 1'b0, m_imm[0], m_fmt[0], m_ill[0]);
                ref_dec(ins, 1'b1, 1'b1, m_imm[1], m_fmt[1], m_ill[1]);
                m_tag = tg;
            end
            m_valid = acc || (m_valid && !orr && !f);
        end
        @(posedge clk);
        #1;
        check("out_valid_a", {63'b0, vld_a}, {63'b0, m_valid});
        check("out_valid_b", {63'b0, vld_b}, {63'b0, m_valid});
        if (m_valid || r) begin
            check("imm_a", {32'b0, imm_a}, m_imm[0]);
            check("fmt_a", {61'b0, fmt_a}, {61'b0, m_fmt[0]});
            check("ill_a", {63'b0, ill_a}, {63'b0, m_ill[0]});
            check("tag_a", {56'b0, tag_a}, {56'b0, m_tag});
            check("imm_b", imm_b, m_imm[1]);
            check("fmt_b", {61'b0, fmt_b}, {61'b0, m_fmt[1]});
            check("ill_b", {63'b0, ill_b}, {63'b0, m_ill[1]});
            check("tag_b", {56'b0, tag_b}, {56'b0, m_tag});
        end
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [63:0] imm;    // value when legal, RV64 view
        logic [2:0]  fmt0;   // RV32, no W ops
        logic        ill0;
        logic [2:0]  fmt1;   // RV64, W ops
        logic        ill1;
    } vec_t;

    vec_t vt [14];

    logic [6:0] ops [13] = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h1B, 7'h23, 7'h33,
                             7'h37, 7'h3B, 7'h63, 7'h67, 7'h6F, 7'h73};

    initial begin
        vt[0]  = '{32'hFFF00093, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0, 3'd1, 1'b0}; // addi -1
        vt[1]  = '{32'hFE000EE3, 64'hFFFFFFFFFFFFFFFC, 3'd3, 1'b0, 3'd3, 1'b0}; // beq -4
        vt[2]  = '{32'h800002B7, 64'hFFFFFFFF80000000, 3'd4, 1'b0, 3'd4, 1'b0}; // lui
        vt[3]  = '{32'h0000009B, 64'h0,                3'd0, 1'b1, 3'd1, 1'b0}; // addiw
        vt[4]  = '{32'h00A12423, 64'h8,                3'd2, 1'b0, 3'd2, 1'b0}; // sw 8
        vt[5]  = '{32'h0080006F, 64'h8,                3'd5, 1'b0, 3'd5, 1'b0}; // jal 8
        vt[6]  = '{32'h00B50533, 64'h0,                3'd0, 1'b0, 3'd0, 1'b0}; // add
        vt[7]  = '{32'h00000000, 64'h0,                3'd0, 1'b1, 3'd0, 1'b1}; // compressed space
        vt[8]  = '{32'h0000003B, 64'h0,                3'd0, 1'b1, 3'd0, 1'b0}; // addw
        vt[9]  = '{32'h12345017, 64'h12345000,         3'd4, 1'b0, 3'd4, 1'b0}; // auipc
        vt[10] = '{32'h0000000B, 64'h0,                3'd0, 1'b1, 3'd0, 1'b1}; // custom-0
        vt[11] = '{32'h00008067, 64'h0,                3'd1, 1'b0, 3'd1, 1'b0}; // ret
        vt[12] = '{32'h80000073, 64'hFFFFFFFFFFFFF800, 3'd1, 1'b0, 3'd1, 1'b0}; // system
        vt[13] = '{32'hFFDFF0EF, 64'hFFFFFFFFFFFFFFFC, 3'd5, 1'b0, 3'd5, 1'b0}; // jal -4

        m_valid = 1'b0;
        m_tag   = '0;
        for (int unsigned k = 0; k < 2; k++) begin
            m_imm[k] = '0; m_fmt[k] = '0; m_ill[k] = 1'b0;
        end
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_tag = '0;
        @(posedge clk);
        #1;
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 8'h0);

        // Table: back-to-back accepts with the consumer always ready.
        for (int i = 0; i < 14; i++) begin
            logic [7:0] tg;
            tg = (i == 1) ? 8'h5A : 8'(i + 16);
            step(1'b0, 1'b0, 1'b1, 1'b1, vt[i].instr, tg);
            check("tbl_valid", {63'b0, vld_a & vld_b}, 64'd1);
            check("tbl_imm_a", {32'b0, imm_a}, vt[i].ill0 ? 64'h0 : {32'b0, vt[i].imm[31:0]});
            check("tbl_fmt_a", {61'b0, fmt_a}, {61'b0, vt[i].fmt0});
            check("tbl_ill_a", {63'b0, ill_a}, {63'b0, vt[i].ill0});
            check("tbl_imm_b", imm_b, vt[i].ill1 ? 64'h0 : vt[i].imm);
            check("tbl_fmt_b", {61'b0, fmt_b}, {61'b0, vt[i].fmt1});
            check("tbl_ill_b", {63'b0, ill_b}, {63'b0, vt[i].ill1});
            check("tbl_tag", {56'b0, tag_b}, {56'b0, tg});
        end

        // Backpressure: A held for three stalled cycles, then drained while B enters.
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'hFFF00093, 8'h11);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0, 32'hFE000EE3, 8'h22);
            check("bp_hold_tag", {56'b0, tag_a}, 64'h11);
            check("bp_hold_imm", {32'b0, imm_a}, 64'hFFFFFFFF);
        end
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'hFE000EE3, 8'h22);
        check("bp_b_tag", {56'b0, tag_a}, 64'h22);
        check("bp_b_imm", {32'b0, imm_a}, 64'hFFFFFFFC);

        // Flush while stalled, flush while ready, then reset together with flush.
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'h00A12423, 8'h33);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0080006F, 8'h44);
        check("flush_stalled", {63'b0, vld_b}, 64'd0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'h12345017, 8'h55);
        check("flush_drop", {63'b0, vld_b}, 64'd0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'h800002B7, 8'h66);
        step(1'b1, 1'b1, 1'b1, 1'b1, 32'hFFF00093, 8'h77);
        check("rst_imm_b", imm_b, 64'h0);
        check("rst_tag_b", {56'b0, tag_b}, 64'h0);

        // Random traffic against the reference model.
        for (int n = 0; n < 600; n++) begin
            logic [31:0] ins;
            ins = $urandom;
            if ($urandom_range(0, 7) != 0) ins[6:0] = ops[$urandom_range(0, 12)];
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
                 ins, 8'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
